// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, runs fixed-latency MULT/DIV ops, executes MTHI/MTLO directly.
// Latency: MULT/MULTU MULT_CYCLES busy cycles, DIV/DIVU DIV_CYCLES busy cycles, MTHI/MTLO one edge.
// Backpressure: combinational D_stall holds an MD-using D instruction while an op is issuing or busy.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_start,
   input  logic [2:0]  E_mdop,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic        D_md_use,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        D_stall
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mdiv_start;
   logic        div_signed;
   logic [63:0] prod;
   logic [31:0] div_n, div_d, q_mag, r_mag, quot, rem;

   assign is_mdiv_start = E_start && (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU);

   assign busy    = (state_q == RUN);
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign D_stall = D_md_use && (busy || is_mdiv_start);

   // Result datapath from the captured operands; signed divide works on magnitudes so
   // 0x80000000 / -1 falls out naturally as 0x80000000 with no overflow special case.
   always_comb begin
      div_signed = (op_q == OP_DIV);
      if (op_q == OP_MULT) begin
         prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      end else begin
         prod = {32'd0, a_q} * {32'd0, b_q};
      end
      div_n = (div_signed && a_q[31]) ? -a_q : a_q;
      div_d = (div_signed && b_q[31]) ? -b_q : b_q;
      if (div_d == 32'd0) begin
         div_d = 32'd1;   // avoid divide-by-zero; the result is discarded anyway
      end
      q_mag = div_n / div_d;
      r_mag = div_n % div_d;
      quot  = (div_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
      rem   = (div_signed && a_q[31]) ? -r_mag : r_mag;
   end

   // Next-state: issue/capture in IDLE, count down in RUN and commit HI/LO on the last edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (is_mdiv_start) begin
               op_d    = E_mdop;
               a_d     = E_rs;
               b_d     = E_rt;
               cnt_d   = (E_mdop <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
               state_d = RUN;
            end else if (E_start && E_mdop == OP_MTHI) begin
               hi_d = E_rs;
            end else if (E_start && E_mdop == OP_MTLO) begin
               lo_d = E_rs;
            end
         end
         RUN: begin
            if (cnt_q == 4'd1) begin
               cnt_d   = 4'd0;
               state_d = IDLE;
               if (op_q <= OP_MULTU) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset aborts any running op and clears HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: table of MD ops with hand-computed HI/LO and busy lengths, plus corner sequences.
// Latency: each op is followed until busy drops; the next op issues in that first idle cycle.
// Backpressure: D_stall is checked at issue and on every busy cycle.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_start;
   logic [2:0]  E_mdop;
   logic [31:0] E_rs;
   logic [31:0] E_rt;
   logic        D_md_use;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        D_stall;

   int n_checks = 0;
   int n_fail   = 0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .E_start  (E_start),
      .E_mdop   (E_mdop),
      .E_rs     (E_rs),
      .E_rt     (E_rt),
      .D_md_use (D_md_use),
      .busy     (busy),
      .HI       (HI),
      .LO       (LO),
      .D_stall  (D_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge: issue op for one cycle, follow busy, check result in first idle cycle.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic md_use, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      E_start  = 1'b1;
      E_mdop   = op;
      E_rs     = rs;
      E_rt     = rt;
      D_md_use = md_use;
      #1;
      check({name, " stall_at_issue"}, 32'(D_stall), 32'(md_use && op >= 3'd1 && op <= 3'd4));
      @(posedge clk);
      @(negedge clk);
      E_start = 1'b0;
      E_mdop  = 3'd0;
      E_rs    = $urandom;
      E_rt    = $urandom;
      n = 0;
      while (busy && n < 40) begin
         check({name, " stall_while_busy"}, 32'(D_stall), 32'(md_use));
         n++;
         @(negedge clk);
      end
      check({name, " busy_cycles"}, 32'(n), 32'(exp_cyc));
      check({name, " busy_low"}, 32'(busy), 32'd0);
      check({name, " stall_after"}, 32'(D_stall), 32'd0);
      check({name, " HI"}, HI, exp_hi);
      check({name, " LO"}, LO, exp_lo);
   endtask

   initial begin
      int n;
      vecs[0]  = '{"mult_neg",     3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{"multu_big",    3'd2, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{"div_neg",      3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{"div_ovf",      3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[4]  = '{"mthi",         3'd5, 32'h00000011, 32'h0,        0,  32'h00000011, 32'h80000000};
      vecs[5]  = '{"mtlo",         3'd6, 32'h00000022, 32'h0,        0,  32'h00000011, 32'h00000022};
      vecs[6]  = '{"divu_zero",    3'd4, 32'h12345678, 32'h0,        10, 32'h00000011, 32'h00000022};
      vecs[7]  = '{"op_reserved",  3'd7, 32'hAAAAAAAA, 32'h5,        0,  32'h00000011, 32'h00000022};
      vecs[8]  = '{"op_none",      3'd0, 32'hBBBBBBBB, 32'h5,        0,  32'h00000011, 32'h00000022};
      vecs[9]  = '{"divu_100_7",   3'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
      vecs[10] = '{"div_7_m2",     3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[11] = '{"mult_minmin",  3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
      vecs[12] = '{"multu_2e32",   3'd2, 32'h80000000, 32'd2,        5,  32'h00000001, 32'h00000000};

      reset    = 1'b1;
      E_start  = 1'b0;
      E_mdop   = 3'd0;
      E_rs     = 32'd0;
      E_rt     = 32'd0;
      D_md_use = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset HI", HI, 32'd0);
      check("reset LO", LO, 32'd0);
      check("reset stall", 32'(D_stall), 32'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b1,
                vecs[i].cyc, vecs[i].hi, vecs[i].lo);
      end

      // Reset in the middle of a DIV clears HI/LO rather than committing a result.
      run_op("mtlo_pre", 3'd6, 32'h33, 32'd0, 1'b1, 0, 32'h1, 32'h33);
      E_start = 1'b1; E_mdop = 3'd3; E_rs = 32'd50; E_rt = 32'd3; D_md_use = 1'b1;
      @(posedge clk);
      @(negedge clk);
      E_start = 1'b0; E_mdop = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_run busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_run busy", 32'(busy), 32'd0);
      check("rst_run HI", HI, 32'd0);
      check("rst_run LO", LO, 32'd0);
      check("rst_run stall", 32'(D_stall), 32'd0);

      // Operands change during RUN and an MTLO start arrives mid-op: both must be ignored.
      E_start = 1'b1; E_mdop = 3'd1; E_rs = 32'd6; E_rt = 32'd7; D_md_use = 1'b1;
      @(posedge clk);
      @(negedge clk);
      E_start = 1'b0; E_mdop = 3'd0; E_rs = 32'd100; E_rt = 32'd100;
      @(negedge clk);
      E_start = 1'b1; E_mdop = 3'd6; E_rs = 32'hDEADBEEF;
      @(negedge clk);
      E_start = 1'b0; E_mdop = 3'd0;
      n = 3;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("capture busy_cycles", 32'(n - 1), 32'd5);
      check("capture HI", HI, 32'd0);
      check("capture LO", LO, 32'd42);

      // With no MD instruction in D, the stall never rises.
      run_op("mult_nouse", 3'd1, 32'd3, 32'd4, 1'b0, 5, 32'd0, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the E stage of the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and runs the fixed-latency multi-cycle operation. It owns the HI/LO registers and raises the D-stage stall that keeps dependent instructions from advancing into the E/M pipeline register until results are valid.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- E_start  input  1  E-stage instruction is a multiply/divide-class op this cycle
- E_mdop  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- E_rs  input  32  forwarded rs operand
- E_rt  input  32  forwarded rt operand
- D_md_use  input  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- busy  output  1  multi-cycle operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- D_stall  output  1  freeze F/D and insert bubble into E

## Operation
- State: IDLE / RUN, plus a 4-bit down-counter cnt, captured op, and captured operands A/B.
- IDLE, E_start=1, op 1–4: capture op, A=E_rs, B=E_rt; cnt ← MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, E_start=1, op 5: HI ← E_rs at that edge. Op 6: LO ← E_rs. Stay IDLE.
- IDLE, E_start=1, op 0 or 7: no effect.
- RUN: cnt decrements each edge. At the edge where cnt==1, write HI/LO, cnt ← 0, go IDLE.
- E_start while in RUN is ignored: no capture and no HI/LO write. D_stall guarantees this never occurs in legal flow.
- Operands are captured at start. Later changes on E_rs/E_rt have no effect.
- MULT: {HI,LO} = signed 64-bit A×B. MULTU: unsigned 64-bit product.
- DIV, signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- B==0 for DIV/DIVU: HI/LO are left unchanged, but the full DIV_CYCLES busy period still elapses.
- busy = (state==RUN).
- D_stall = D_md_use & (busy | (E_start & E_mdop∈{1..4})). This output is combinational.
- MFHI/MFLO in E read HI/LO directly. HI/LO are never observed mid-operation because of the stall.

## Timing
- Reset values: busy=0, HI=0, LO=0, D_stall=0 (given D_md_use=0 or no start), state IDLE, cnt=0.
- Reset asserted during RUN aborts the operation. HI/LO are cleared, not written with a result.
- Start sampled at edge T: busy is high in cycles T+1 … T+N, where N = configured cycles.
  - HI/LO are written at edge T+N and are valid from cycle T+N+1. busy is low in that same cycle.
  - Stall covers the issue cycle T and cycles T+1 … T+N. A dependent instruction enters E in cycle T+N+1.
- MTHI/MTLO latency: 1 edge. The value is visible the next cycle. There is no busy and no stall.
- Back-to-back: a new start is accepted in the first cycle busy=0. Zero-bubble reissue is permitted.
- Non-MD instructions flow through D/E/M unaffected while busy=1.

## Test plan
- Reset, then MULT with rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA on cycle 6; D_stall high while D_md_use=1.
- MULTU with rs=0xFFFFFFFF, rt=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV with rs=−7 (0xFFFFFFF9), rt=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 by −1 → LO=0x80000000, HI=0.
- DIVU with rt=0 and HI/LO preloaded via MTHI 0x11, MTLO 0x22 → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Start DIV, assert reset at busy cycle 4 → next cycle busy=0, HI=LO=0.
- Start MULT, change E_rs/E_rt during RUN, and pulse E_start with MTLO at cycle 2 → result uses captured operands; LO is not overwritten by MTLO.
- Start MULT with D_md_use=0 and non-MD instructions in flight → D_stall stays 0 throughout.
